// File: rtl/det_sched_pkg.sv
// ============================================================================
// Module      : det_sched_pkg
// Description : Shared types and default widths for the determinant job
//               scheduler and its job FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package det_sched_pkg;

  localparam int DEF_QUEUE_DEPTH = 4;
  localparam int DEF_ADDR_W      = 4;
  localparam int DEF_DATA_W      = 16;

  // Scheduler sequencing states; the 2-bit encoding is fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/det_job_fifo.sv
// ============================================================================
// Module      : det_job_fifo
// Description : Small synchronous FIFO holding queued job start addresses.
//               Full/empty are decoded from the registered occupancy count,
//               so a pop never frees a slot for a push in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module det_job_fifo
  import det_sched_pkg::*;
#(
  parameter int DEPTH = DEF_QUEUE_DEPTH,
  parameter int WIDTH = DEF_ADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Next-state for storage, pointers (wrap naturally at power-of-2 depth) and count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset flushes contents and pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/det_job_scheduler.sv
// ============================================================================
// Module      : det_job_scheduler
// Description : Queues ROM start addresses from a host, runs the determinant
//               calculator one job at a time, and hands each result back with
//               its address over a valid/ready handshake.
//               Optional build macro DET_SCHED_STATS_EN adds jobs_done/busy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module det_job_scheduler
  import det_sched_pkg::*;
#(
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_valid,
  input  logic [ADDR_W-1:0] job_address,
  output logic              job_ready,
  output logic              calc_start,
  output logic [ADDR_W-1:0] calc_start_address,
  input  logic              calc_done,
  input  logic [DATA_W-1:0] calc_result,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [ADDR_W-1:0] res_address,
  input  logic              res_ready
`ifdef DET_SCHED_STATS_EN
  ,
  output logic [15:0]       jobs_done,
  output logic [0:0]        busy
`endif
);

  sched_state_t      state_q, state_d;
  logic              done_q, done_d;
  logic              calc_start_q, calc_start_d;
  logic [ADDR_W-1:0] calc_addr_q, calc_addr_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic [ADDR_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              done_evt;

  assign job_ready = ~fifo_full;
  assign fifo_push = job_valid & ~fifo_full;

  det_job_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ADDR_W)
  ) u_job_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (job_address),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Only a rising edge of done counts, so a level left high by the previous
  // job cannot complete the next one.
  assign done_d   = calc_done;
  assign done_evt = calc_done & ~done_q;

  // Next state and registered outputs; the head address is latched on the
  // way into START so it is valid alongside the start pulse.
  always_comb begin
    state_d      = state_q;
    calc_start_d = 1'b0;
    calc_addr_d  = calc_addr_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_addr_d   = res_addr_q;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d      = ST_START;
          calc_start_d = 1'b1;
          calc_addr_d  = fifo_head;
          res_addr_d   = fifo_head;
        end
      end
      ST_START: begin
        fifo_pop = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_evt) begin
          res_data_d  = calc_result;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scheduler state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      done_q       <= 1'b0;
      calc_start_q <= 1'b0;
      calc_addr_q  <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      calc_start_q <= calc_start_d;
      calc_addr_q  <= calc_addr_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_addr_q   <= res_addr_d;
    end
  end

  assign calc_start         = calc_start_q;
  assign calc_start_address = calc_addr_q;
  assign res_valid          = res_valid_q;
  assign res_data           = res_data_q;
  assign res_address        = res_addr_q;

`ifdef DET_SCHED_STATS_EN
  logic [15:0] jobs_done_q, jobs_done_d;

  // Completed-job counter, stepped on every result handshake; wraps freely.
  always_comb begin
    jobs_done_d = jobs_done_q;
    if (res_valid_q && res_ready) begin
      jobs_done_d = jobs_done_q + 16'd1;
    end
  end

  // Completed-job counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      jobs_done_q <= '0;
    end else begin
      jobs_done_q <= jobs_done_d;
    end
  end

  assign jobs_done = jobs_done_q;
  assign busy      = (state_q != ST_IDLE) | ~fifo_empty;
`endif

endmodule

`default_nettype wire

// File: doc/det_job_scheduler.md
Name: det_job_scheduler

Overview:
- Sequences the determinant datapath: queues start addresses from a host, fires `start` on determinant_calculator one job at a time, waits for `done`, then returns each 16-bit result with its address over a valid/ready handshake.
- Sits between the host and the determinant_calculator / ROM pair at top level.
- Lets multiple matrices in ROM be processed back-to-back without the host tracking datapath busy state.

Parameters:
- QUEUE_DEPTH, 4, job FIFO entries; power of 2, minimum 2.
- ADDR_W, 4, ROM start-address width.
- DATA_W, 16, determinant result width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- job_valid  input  1  host offers a job.
- job_address  input  ADDR_W  ROM start address of the matrix.
- job_ready  output  1  FIFO not full; a job is accepted when job_valid&&job_ready.
- calc_start  output  1  start pulse to determinant_calculator.
- calc_start_address  output  ADDR_W  start address to determinant_calculator.
- calc_done  input  1  done from determinant_calculator; level or pulse.
- calc_result  input  DATA_W  determinant_calculator output.
- res_valid  output  1  result available.
- res_data  output  DATA_W  captured determinant.
- res_address  output  ADDR_W  start address the result belongs to.
- res_ready  input  1  host consumes the result.

Behaviour:
- Reset values:
  - job_ready=1; calc_start=0; calc_start_address=0; res_valid=0; res_data=0; res_address=0.
  - FIFO empty; FSM in IDLE; done_q=0.
- Job FIFO:
  - Depth QUEUE_DEPTH; job_ready=!full, registered.
  - A push while full is impossible, even if a pop occurs in the same cycle; job_ready does not look ahead.
  - Pointers wrap modulo QUEUE_DEPTH.
  - Count is held in ceil(log2(QUEUE_DEPTH))+1 bits.
- Done detection: done_q registers calc_done; done_evt = calc_done & ~done_q, a rising edge only. A `done` level left high from the previous job is therefore never mistaken for completion.
- FSM is Moore; all outputs are registered.
  - IDLE: if FIFO non-empty -> START.
  - START:
    - calc_start=1 for exactly one cycle.
    - calc_start_address <= FIFO head, also latched into res_address.
    - Pop the FIFO; -> WAIT.
  - WAIT:
    - calc_start=0; calc_start_address held stable.
    - On done_evt: res_data <= calc_result; res_valid <= 1; -> HOLD.
    - No timeout.
  - HOLD:
    - res_valid, res_data and res_address stay stable until res_valid&&res_ready.
    - On that handshake: res_valid <= 0; -> IDLE.
    - A done_evt seen in HOLD is ignored.
- Latency:
  - A job accepted at cycle N into an empty FIFO while in IDLE gives calc_start=1 at cycle N+2.
  - Result: res_valid rises the cycle after the cycle in which done_evt is seen.
- Simultaneous push and pop in the START cycle: the count is unchanged and both the entry and pointers update correctly.
- Order: results are returned strictly in job-acceptance order. Only one job is ever in flight.
- Reset mid-operation:
  - FIFO flushed; FSM -> IDLE; res_valid drops; any in-flight job is discarded.
  - The calculator shares `reset`, so it also aborts.
- Arithmetic: calc_result is passed through unmodified; no sign or width conversion.

Optional Feature:
- Macro: DET_SCHED_STATS_EN.
- When defined:
  - Adds output jobs_done [15:0], reset to 0.
  - Increments on each result handshake (res_valid&&res_ready) and wraps from 0xFFFF to 0.
  - Adds output busy [0:0], =1 whenever the FSM is not in IDLE or the FIFO is non-empty.
- When undefined: neither port nor the counter logic exists; the rest of the behaviour is identical.

Decomposition:
- Package det_sched_pkg holds:
  - state enum {IDLE, START, WAIT, HOLD} with a 2-bit encoding.
  - ADDR_W=4 and DATA_W=16 defaults.
- Sub-module det_job_fifo:
  - Synchronous FIFO with push/pop/full/empty/head.
  - Parameterised by depth and width; instantiated once with width ADDR_W.

Test Plan:
- Reset, then push job address 0x0 at cycle N with the calculator modelled as done 5 cycles after start, result 0x0012 -> calc_start=1 at N+2 only; calc_start_address=0; res_valid with res_data=0x0012, res_address=0.
- Push 0x0,0x4,0x8 back-to-back with res_ready=1 and results 0x0003/0xFFFE/0x0000 -> three calc_start pulses with addresses 0,4,8 in order; results returned in the same order.
- Push 5 jobs with a stalled datapath (QUEUE_DEPTH=4) -> job_ready=0 after 4 accepted in FIFO; 5th held until the pop in the START cycle; no job lost.
- calc_done held high across two jobs, rising once per job -> exactly one result per rising edge; no duplicate.
- res_ready=0 for 10 cycles in HOLD with extra jobs queued -> res_data stable; no calc_start issued until the handshake.
- reset asserted during WAIT with 2 jobs queued -> next cycle: FSM IDLE, FIFO empty, job_ready=1, res_valid=0; with DET_SCHED_STATS_EN, jobs_done=0.
